// File: rtl/and_frame_accumulator.sv
// Frame accumulator for the 1-bit output of an AND-gate tree: groups FRAME_LEN
// accepted samples, then presents their AND and ones-count until the sink takes it.
module and_frame_accumulator #(
  parameter int FRAME_LEN = 4,
  parameter int CNT_W     = 3,
  parameter int FRM_W     = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic             i_bit,
  output logic             o_ready,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_result,
  output logic [CNT_W-1:0] o_ones,
  output logic [FRM_W-1:0] o_frames
);

  // Handshakes: a sample transfers on a rising edge with i_valid && o_ready;
  // a result transfers on a rising edge with o_valid && i_ready. Both ready and
  // valid come straight from the state register, so nothing is combinational.
  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  state_e             state_q;
  logic               acc_q;
  logic [CNT_W-1:0]   idx_q;
  logic [CNT_W-1:0]   ones_q;
  logic               result_q;
  logic [CNT_W-1:0]   ones_out_q;
  logic [FRM_W-1:0]   frames_q;

  logic               acc_d;
  logic [CNT_W-1:0]   idx_d;
  logic [CNT_W-1:0]   ones_d;
  logic [FRM_W-1:0]   frames_d;

  always_comb begin
    acc_d    = acc_q & i_bit;
    idx_d    = idx_q + CNT_W'(1);
    ones_d   = ones_q + CNT_W'(i_bit);
    frames_d = frames_q + FRM_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= ACCUM;
      acc_q      <= 1'b1;
      idx_q      <= '0;
      ones_q     <= '0;
      result_q   <= 1'b0;
      ones_out_q <= '0;
      frames_q   <= '0;
    end else if (i_flush) begin
      // Flush drops the partial frame and any pending result; the last
      // result/ones values are left alone since they are only read under o_valid.
      state_q <= ACCUM;
      acc_q   <= 1'b1;
      idx_q   <= '0;
      ones_q  <= '0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (i_valid) begin
            if (idx_q == LAST_IDX) begin
              result_q   <= acc_d;
              ones_out_q <= ones_d;
              acc_q      <= 1'b1;
              idx_q      <= '0;
              ones_q     <= '0;
              state_q    <= HOLD;
            end else begin
              acc_q  <= acc_d;
              idx_q  <= idx_d;
              ones_q <= ones_d;
            end
          end
        end
        HOLD: begin
          if (i_ready) begin
            frames_q <= frames_d;
            state_q  <= ACCUM;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign o_ready  = (state_q == ACCUM);
  assign o_valid  = (state_q == HOLD);
  assign o_result = result_q;
  assign o_ones   = ones_out_q;
  assign o_frames = frames_q;

endmodule

// File: tb/tb_and_frame_accumulator.sv
// Bench for and_frame_accumulator: directed steps plus random traffic, checked
// each cycle against a frame-level reference built from a queue of sample bits.
module tb_and_frame_accumulator;

  localparam int FRAME_LEN = 4;
  localparam int CNT_W     = 3;
  localparam int FRM_W     = 8;

  logic             clk;
  logic             rst_n;
  logic             valid_i;
  logic             bit_i;
  logic             ready_o;
  logic             flush_i;
  logic             valid_o;
  logic             ready_i;
  logic             result_o;
  logic [CNT_W-1:0] ones_o;
  logic [FRM_W-1:0] frames_o;

  int errors = 0;
  int checks = 0;

  // Reference model: bits of the frame in progress, plus the pending result.
  int bits_q[$];
  bit pend      = 0;
  int last_res  = 0;
  int last_ones = 0;
  int frames    = 0;

  and_frame_accumulator #(
    .FRAME_LEN(FRAME_LEN),
    .CNT_W    (CNT_W),
    .FRM_W    (FRM_W)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (valid_i),
    .i_bit   (bit_i),
    .o_ready (ready_o),
    .i_flush (flush_i),
    .o_valid (valid_o),
    .i_ready (ready_i),
    .o_result(result_o),
    .o_ones  (ones_o),
    .o_frames(frames_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit r_n, input bit v, input bit b, input bit f, input bit rd);
    int r;
    int n;
    if (!r_n) begin
      bits_q.delete();
      pend      = 0;
      frames    = 0;
      last_res  = 0;
      last_ones = 0;
    end else if (f) begin
      bits_q.delete();
      pend = 0;
    end else if (pend) begin
      if (rd) begin
        frames = (frames + 1) % (1 << FRM_W);
        pend   = 0;
      end
    end else if (v) begin
      bits_q.push_back(int'(b));
      if (bits_q.size() == FRAME_LEN) begin
        r = 1;
        n = 0;
        foreach (bits_q[k]) begin
          r = r & bits_q[k];
          n = n + bits_q[k];
        end
        last_res  = r;
        last_ones = n;
        pend      = 1;
        bits_q.delete();
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".ready"},  int'(ready_o),  int'(!pend));
    chk({tag, ".valid"},  int'(valid_o),  int'(pend));
    chk({tag, ".result"}, int'(result_o), last_res);
    chk({tag, ".ones"},   int'(ones_o),   last_ones);
    chk({tag, ".frames"}, int'(frames_o), frames);
  endtask

  // One clock: drive inputs, take the edge, advance the model, check 1 ns later.
  task automatic cyc(input string tag, input bit r_n, input bit v, input bit b,
                     input bit f, input bit rd);
    rst_n   = r_n;
    valid_i = v;
    bit_i   = b;
    flush_i = f;
    ready_i = rd;
    @(posedge clk);
    model_step(r_n, v, b, f, rd);
    #1;
    check_outputs(tag);
  endtask

  task automatic send_frame(input string tag, input bit [3:0] bits);
    for (int i = 0; i < FRAME_LEN; i++) cyc(tag, 1, 1, bits[FRAME_LEN-1-i], 0, 0);
  endtask

  initial begin
    rst_n   = 1'b0;
    valid_i = 1'b0;
    bit_i   = 1'b0;
    flush_i = 1'b0;
    ready_i = 1'b0;
    #1;

    cyc("reset", 0, 0, 0, 0, 0);
    cyc("reset", 0, 1, 1, 0, 1);
    chk("reset.ones_const", int'(ones_o), 0);

    // All ones, valid held, sink ready: HOLD lasts one cycle.
    for (int i = 0; i < FRAME_LEN; i++) cyc("ones_frame", 1, 1, 1, 0, 1);
    chk("ones_frame.latency_valid", int'(valid_o), 1);
    chk("ones_frame.result_const", int'(result_o), 1);
    chk("ones_frame.ones_const", int'(ones_o), 4);
    cyc("ones_frame.accept", 1, 1, 1, 0, 1);
    chk("ones_frame.frames_const", int'(frames_o), 1);

    // Frame 0,1,1,1 with two idle cycles between samples.
    begin
      bit [3:0] g;
      g = 4'b0111;
      for (int i = 0; i < FRAME_LEN; i++) begin
        cyc("gaps", 1, 1, g[3-i], 0, 0);
        if (i != FRAME_LEN - 1) begin
          cyc("gaps.idle", 1, 0, 1, 0, 0);
          cyc("gaps.idle", 1, 0, 1, 0, 0);
        end
      end
    end
    chk("gaps.result_const", int'(result_o), 0);
    chk("gaps.ones_const", int'(ones_o), 3);
    cyc("gaps.accept", 1, 0, 0, 0, 1);

    // Backpressure: result held five cycles while upstream keeps offering.
    send_frame("bp", 4'b1011);
    for (int i = 0; i < 5; i++) cyc("bp.hold", 1, 1, 1'($urandom_range(0, 1)), 0, 0);
    cyc("bp.accept", 1, 1, 1, 0, 1);
    send_frame("bp.clean", 4'b1111);
    chk("bp.clean_ones_const", int'(ones_o), 4);
    cyc("bp.clean_accept", 1, 0, 0, 0, 1);

    // Flush after two bits, with a sample offered in the flush cycle.
    cyc("flush", 1, 1, 1, 0, 0);
    cyc("flush", 1, 1, 0, 0, 0);
    cyc("flush.drop", 1, 1, 0, 1, 0);
    send_frame("flush.after", 4'b1111);
    chk("flush.result_const", int'(result_o), 1);
    cyc("flush.accept", 1, 0, 0, 0, 1);

    // Flush beats a simultaneous sink accept in HOLD.
    send_frame("flush_hold", 4'b1101);
    cyc("flush_hold.flush", 1, 0, 0, 1, 1);
    chk("flush_hold.valid_const", int'(valid_o), 0);

    // Reset mid-frame, then a reset pulse with no edge, then reset in HOLD.
    cyc("rst_mid", 1, 1, 1, 0, 0);
    cyc("rst_mid", 1, 1, 1, 0, 0);
    cyc("rst_mid.reset", 0, 1, 1, 0, 0);
    chk("rst_mid.frames_const", int'(frames_o), 0);
    send_frame("rst_glitch", 4'b1111);
    rst_n = 1'b0;
    #2;
    check_outputs("rst_glitch.no_edge");
    rst_n = 1'b1;
    cyc("rst_glitch.accept", 1, 0, 0, 0, 1);
    send_frame("rst_hold", 4'b0110);
    cyc("rst_hold.reset", 0, 0, 0, 0, 1);
    chk("rst_hold.valid_const", int'(valid_o), 0);

    // 256 back-to-back frames wrap the frame counter back to zero.
    for (int fr = 0; fr < 256; fr++) begin
      for (int i = 0; i < FRAME_LEN; i++) cyc("wrap", 1, 1, 1'($urandom_range(0, 1)), 0, 1);
      cyc("wrap.accept", 1, 1, 1, 0, 1);
    end
    chk("wrap.frames_const", int'(frames_o), 0);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 2000; i++) begin
      cyc("rand",
          ($urandom_range(0, 199) != 0),
          1'($urandom_range(0, 1)),
          ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 15) == 0),
          1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/and_frame_accumulator.md
Name: and_frame_accumulator

Overview:
- Downstream consumer of the 1-bit output of the AND-gate tree, e.g. a 4-input AND built from three 2-input gates.
- Samples the gate output under a valid/ready handshake and groups samples into frames of FRAME_LEN bits.
- For each frame, emits the AND of all bits in the frame and the count of ones.
- Output uses a valid/ready handshake and holds the result until the sink accepts it.

Parameters:
- FRAME_LEN, 4: bits per frame; legal range 2..(2**CNT_W)-1.
- CNT_W, 3: width of the bit-index and ones counters; must satisfy FRAME_LEN <= 2**CNT_W - 1.
- FRM_W, 8: width of the emitted-frame counter.

Ports:
- i_clk  input  1  clock; all logic on the rising edge.
- i_rst_n  input  1  reset, synchronous, active-low.
- i_valid  input  1  upstream sample valid.
- i_bit  input  1  sample; the AND-gate result.
- o_ready  output  1  accumulator can accept a sample.
- i_flush  input  1  synchronous abort of the current frame or the pending result.
- o_valid  output  1  frame result valid.
- i_ready  input  1  sink accepts the result.
- o_result  output  1  AND of all FRAME_LEN bits in the frame.
- o_ones  output  CNT_W  number of 1 bits in the frame.
- o_frames  output  FRM_W  count of frames handed to the sink; wraps modulo 2**FRM_W.

Behaviour:
- Reset (i_rst_n=0 at a clock edge):
  - state=ACCUM.
  - Internal: acc=1, idx=0, ones=0.
  - Outputs: o_valid=0, o_result=0, o_ones=0, o_frames=0.
  - o_ready=1 from the first cycle after reset releases.
  - Reset mid-frame or mid-HOLD discards everything; no partial result is emitted.
- States: ACCUM, HOLD.
- ACCUM:
  - o_ready=1, o_valid=0.
  - Accept occurs when i_valid=1 and o_ready=1 at a rising edge. On accept: acc<=acc&i_bit, ones<=ones+i_bit, idx<=idx+1.
  - Last bit (accept with idx==FRAME_LEN-1):
    - o_result<=acc&i_bit, o_ones<=ones+i_bit.
    - acc<=1, idx<=0, ones<=0.
    - state<=HOLD.
  - Latency: o_valid=1 on the cycle after the last bit is accepted.
  - i_valid=0: no change. Gaps between samples are allowed.
- HOLD:
  - o_ready=0, o_valid=1.
  - o_result and o_ones are stable until accepted.
  - Accept occurs when i_ready=1 at a rising edge. On accept: o_frames<=o_frames+1, state<=ACCUM; o_valid=0 the next cycle.
  - i_valid asserted in HOLD is ignored; no sample is consumed.
- Throughput:
  - One frame per FRAME_LEN+1 cycles minimum: FRAME_LEN accept cycles plus 1 HOLD cycle with i_ready=1.
  - No skid buffer.
- i_flush (highest priority after reset):
  - In ACCUM: acc<=1, idx<=0, ones<=0. A sample presented in the same cycle is dropped, even with i_valid=1, because flush wins.
  - In HOLD: the pending result is discarded and state<=ACCUM; o_frames is not incremented, even if i_ready=1 in the same cycle.
  - o_result and o_ones keep their last values; they are only meaningful while o_valid=1.
- Widths: ones never exceeds FRAME_LEN, so no overflow. o_frames wraps from 2**FRM_W-1 to 0.
- No combinational path from any input to any output. o_ready and o_valid decode from the state register only.

Test Plan:
- Reset, then FRAME_LEN=4 bits 1,1,1,1 with i_valid held high and i_ready=1:
  - o_valid=1 exactly 1 cycle after the 4th accept.
  - o_result=1, o_ones=4.
  - o_frames=1 after the handshake.
  - o_ready=0 during HOLD.
- Bits 0,1,1,1 (first gate pair a=0,b=1) with idle gaps of 2 cycles between samples:
  - o_result=0, o_ones=3.
  - Gaps do not advance idx.
- Backpressure: frame 1,0,1,1 completes with i_ready=0 for 5 cycles and i_valid=1 throughout:
  - o_valid, o_result=0 and o_ones=3 stay stable for all 5 cycles.
  - No sample is consumed; idx stays 0.
  - After i_ready=1, the next frame starts clean.
- i_flush after 2 accepted bits (1,0), asserted together with i_valid=1 and i_bit=0, then bits 1,1,1,1:
  - The flushed sample is dropped.
  - The emitted frame is o_result=1, o_ones=4.
  - o_frames increments by 1 only.
- i_flush and i_ready both high in HOLD:
  - o_valid drops, o_frames is unchanged, state returns to ACCUM.
- Synchronous reset asserted mid-frame (idx=2) and separately in HOLD:
  - All outputs return to reset values on the next edge; o_frames=0.
  - Reset asserted with no clock edge has no effect.
- Wrap: 256 back-to-back frames with FRM_W=8 -> o_frames returns to 0.
